// File: rtl/demux1to4_phased.sv
// Phased 1:4 demultiplexer: routes one accepted word to lane a/b/c/d through the
// four-phase power-clock sequence IDLE -> RAMP -> HOLD -> RECOVER, with registered outputs.
module demux1to4_phased #(
  parameter int WIDTH       = 1,
  parameter int RAMP_CYCLES = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             in0,
  input  logic             in1,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             clkpos,
  output logic             clkneg
);

  localparam int MAXC = (RAMP_CYCLES > HOLD_CYCLES) ? RAMP_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  generate
    if (RAMP_CYCLES < 1) begin : g_bad_ramp
      $error("demux1to4_phased: RAMP_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("demux1to4_phased: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_next;
  logic [WIDTH-1:0]        r_din;
  logic [1:0]              r_sel;
  logic                    w_accept;
  logic [3:0][WIDTH-1:0]   w_lane_next;
  logic [3:0][WIDTH-1:0]   r_lane;
  logic                    r_out_valid;
  logic                    r_clkpos;

  // Gated by rst so upstream never sees a handshake while reset is asserted.
  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_RAMP;
          w_cnt_next   = CW'(RAMP_CYCLES - 1);
        end
      end
      S_RAMP: begin
        if (r_cnt == '0) begin
          w_state_next = S_HOLD;
          w_cnt_next   = CW'(HOLD_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = S_RECOVER;
          w_cnt_next   = CW'(RAMP_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_RECOVER: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Word and select are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din <= '0;
      r_sel <= '0;
    end else if (w_accept) begin
      r_din <= din;
      r_sel <= {in1, in0};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_next[gi] = ((r_state == S_HOLD) && (r_sel == 2'(gi))) ? r_din : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane      <= '0;
      r_out_valid <= 1'b0;
      r_clkpos    <= 1'b0;
    end else begin
      r_lane      <= w_lane_next;
      r_out_valid <= (r_state == S_HOLD);
      r_clkpos    <= (r_state == S_RAMP) || (r_state == S_HOLD);
    end
  end

  assign a         = r_lane[0];
  assign b         = r_lane[1];
  assign c         = r_lane[2];
  assign d         = r_lane[3];
  assign out_valid = r_out_valid;
  assign clkpos    = r_clkpos;
  assign clkneg    = ~r_clkpos;

endmodule

// File: tb/tb_demux1to4_phased.sv
// Directed bench for demux1to4_phased: default instance plus a WIDTH=4/RAMP=3/HOLD=1 instance.
module tb_demux1to4_phased;

  logic clk;
  logic rst;

  logic       in_valid, in_ready, din, in0, in1;
  logic       a, b, c, d, out_valid, clkpos, clkneg;

  logic       in_valid6, in_ready6, in06, in16;
  logic [3:0] din6, a6, b6, c6, d6;
  logic       out_valid6, clkpos6, clkneg6;

  int n_vec;
  int n_err;

  demux1to4_phased dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .in0(in0), .in1(in1), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .clkpos(clkpos), .clkneg(clkneg)
  );

  demux1to4_phased #(.WIDTH(4), .RAMP_CYCLES(3), .HOLD_CYCLES(1)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .din(din6),
    .in0(in06), .in1(in16), .a(a6), .b(b6), .c(c6), .d(d6),
    .out_valid(out_valid6), .clkpos(clkpos6), .clkneg(clkneg6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk("idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Accepts one word on the default instance and checks every cycle until IDLE again.
  task automatic run_word(input logic dv, input logic [1:0] s);
    logic hold;
    wait_idle();
    in_valid = 1'b1; din = dv; {in1, in0} = s;
    tick();
    in_valid = 1'b0; din = ~dv; {in1, in0} = ~s;
    $display("word din=%0d sel=%0d accepted", dv, s);
    for (int cy = 1; cy <= 6; cy++) begin
      tick();
      hold = (cy == 3) || (cy == 4);
      chk("out_valid", {31'd0, out_valid}, {31'd0, hold});
      chk("lane_a", {31'd0, a}, {31'd0, (hold && s == 2'd0) ? dv : 1'b0});
      chk("lane_b", {31'd0, b}, {31'd0, (hold && s == 2'd1) ? dv : 1'b0});
      chk("lane_c", {31'd0, c}, {31'd0, (hold && s == 2'd2) ? dv : 1'b0});
      chk("lane_d", {31'd0, d}, {31'd0, (hold && s == 2'd3) ? dv : 1'b0});
      chk("clkpos", {31'd0, clkpos}, {31'd0, cy <= 4});
      chk("clkneg", {31'd0, clkneg}, {31'd0, cy > 4});
      chk("in_ready", {31'd0, in_ready}, {31'd0, cy == 6});
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    in_valid = 1'b0; din = 1'b0; in0 = 1'b0; in1 = 1'b0;
    in_valid6 = 1'b0; din6 = 4'h0; in06 = 1'b0; in16 = 1'b0;

    // Reset held for three edges with a word offered.
    rst = 1'b1; in_valid = 1'b1; din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_abcd", {28'd0, a, b, c, d}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_clkneg", {31'd0, clkneg}, 32'd1);
      chk("rst_clkpos", {31'd0, clkpos}, 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    $display("reset released");

    // One word per lane, then a zero word to lane c.
    for (int s = 0; s < 4; s++) run_word(1'b1, 2'(s));
    run_word(1'b0, 2'd2);

    // Continuous in_valid: one acceptance every 7 cycles.
    wait_idle();
    in_valid = 1'b1; din = 1'b1; {in1, in0} = 2'd3;
    for (int t = 0; t < 30; t++) begin
      chk("stream_ready", {31'd0, in_ready}, {31'd0, (t % 7) == 0});
      if (t % 7 == 0) $display("stream acceptance at cycle %0d", t);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset on the first cycle HOLD data is visible, then immediate re-acceptance.
    in_valid = 1'b1; din = 1'b1; {in1, in0} = 2'd1;
    tick();
    in_valid = 1'b0;
    for (int cy = 1; cy <= 3; cy++) tick();
    chk("pre_rst_b", {31'd0, b}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_abcd", {28'd0, a, b, c, d}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_clkpos", {31'd0, clkpos}, 32'd0);
    chk("midrst_clkneg", {31'd0, clkneg}, 32'd1);
    rst = 1'b0;
    in_valid = 1'b1; din = 1'b1; {in1, in0} = 2'd3;
    #1;
    chk("postrst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("postrst_accepted", {31'd0, in_ready}, 32'd0);
    for (int cy = 1; cy <= 3; cy++) tick();
    chk("postrst_d", {31'd0, d}, 32'd1);
    chk("postrst_b", {31'd0, b}, 32'd0);
    $display("mid-HOLD reset word replaced by sel=3 word");
    wait_idle();

    // WIDTH=4, RAMP=3, HOLD=1 instance: select flipped during RAMP has no effect.
    in_valid6 = 1'b1; din6 = 4'hA; {in16, in06} = 2'd1;
    tick();
    in_valid6 = 1'b0;
    for (int cy = 1; cy <= 7; cy++) begin
      if (cy == 1) {in16, in06} = 2'd3;
      tick();
      chk("w4_b", {28'd0, b6}, (cy == 4) ? 32'hA : 32'd0);
      chk("w4_d", {28'd0, d6}, 32'd0);
      chk("w4_out_valid", {31'd0, out_valid6}, {31'd0, cy == 4});
      chk("w4_in_ready", {31'd0, in_ready6}, {31'd0, cy == 7});
    end
    $display("w4 word din=A sel=1 done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
